// File: rtl/decode_stage_pipe.sv
// Decode stage: integer register file with write-back bypass, load-use stall
// generation and the ID/EX pipeline register (flush, hold, bubble insertion).
module decode_stage_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned CTRL_W = 24,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [31:0]       instr_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pc_plus4_d,
    input  logic [XLEN-1:0]   imm_ext_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic              is_load_d,
    input  logic              reg_write_w,
    input  logic [AW-1:0]     rd_w,
    input  logic [XLEN-1:0]   result_w,
    input  logic              flush_e,
    input  logic              hold_i,
    output logic              stall_d,
    output logic              valid_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic              is_load_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pc_plus4_e,
    output logic [AW-1:0]     rs1_e,
    output logic [AW-1:0]     rs2_e,
    output logic [AW-1:0]     rd_e
);

    logic [XLEN-1:0]   regs_q [NREG];
    logic [XLEN-1:0]   regs_d [NREG];

    logic [AW-1:0]     rs1_c, rs2_c, rd_c;
    logic [XLEN-1:0]   rd1_c, rd2_c;
    logic              load_use_c;
    logic              unused_instr_bits;

    logic              valid_e_q, valid_e_d;
    logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
    logic              is_load_e_q, is_load_e_d;
    logic [XLEN-1:0]   rd1_e_q, rd1_e_d;
    logic [XLEN-1:0]   rd2_e_q, rd2_e_d;
    logic [XLEN-1:0]   imm_e_q, imm_e_d;
    logic [XLEN-1:0]   pc_e_q, pc_e_d;
    logic [XLEN-1:0]   pc_plus4_e_q, pc_plus4_e_d;
    logic [AW-1:0]     rs1_e_q, rs1_e_d;
    logic [AW-1:0]     rs2_e_q, rs2_e_d;
    logic [AW-1:0]     rd_e_q, rd_e_d;

    assign rs1_c = AW'(instr_d[19:15]);
    assign rs2_c = AW'(instr_d[24:20]);
    assign rd_c  = AW'(instr_d[11:7]);
    assign unused_instr_bits = ^{instr_d[31:25], instr_d[14:12], instr_d[6:0]};

    // Register file write; x0 is never written so it stays at its reset value of 0.
    always_comb begin
        regs_d = regs_q;
        if (reg_write_w && (rd_w != '0)) begin
            regs_d[rd_w] = result_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports with same-cycle write-back bypass.
    always_comb begin
        rd1_c = regs_q[rs1_c];
        rd2_c = regs_q[rs2_c];
        if (reg_write_w && (rd_w == rs1_c)) rd1_c = result_w;
        if (reg_write_w && (rd_w == rs2_c)) rd2_c = result_w;
        if (rs1_c == '0) rd1_c = '0;
        if (rs2_c == '0) rd2_c = '0;
    end

    assign load_use_c = valid_d & valid_e_q & is_load_e_q & (rd_e_q != '0) &
                        ((rd_e_q == rs1_c) | (rd_e_q == rs2_c));
    assign stall_d    = hold_i | (load_use_c & ~flush_e);

    // ID/EX next state: flush beats hold, hold beats load-use bubble, else capture.
    always_comb begin
        valid_e_d    = valid_e_q;
        ctrl_e_d     = ctrl_e_q;
        is_load_e_d  = is_load_e_q;
        rd1_e_d      = rd1_e_q;
        rd2_e_d      = rd2_e_q;
        imm_e_d      = imm_e_q;
        pc_e_d       = pc_e_q;
        pc_plus4_e_d = pc_plus4_e_q;
        rs1_e_d      = rs1_e_q;
        rs2_e_d      = rs2_e_q;
        rd_e_d       = rd_e_q;
        if (flush_e || (!hold_i && load_use_c)) begin
            valid_e_d    = 1'b0;
            ctrl_e_d     = '0;
            is_load_e_d  = 1'b0;
            rd1_e_d      = '0;
            rd2_e_d      = '0;
            imm_e_d      = '0;
            pc_e_d       = '0;
            pc_plus4_e_d = '0;
            rs1_e_d      = '0;
            rs2_e_d      = '0;
            rd_e_d       = '0;
        end else if (!hold_i) begin
            valid_e_d    = valid_d;
            ctrl_e_d     = valid_d ? ctrl_d : '0;
            is_load_e_d  = valid_d & is_load_d;
            rd1_e_d      = rd1_c;
            rd2_e_d      = rd2_c;
            imm_e_d      = imm_ext_d;
            pc_e_d       = pc_d;
            pc_plus4_e_d = pc_plus4_d;
            rs1_e_d      = rs1_c;
            rs2_e_d      = rs2_c;
            rd_e_d       = rd_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_e_q    <= 1'b0;
            ctrl_e_q     <= '0;
            is_load_e_q  <= 1'b0;
            rd1_e_q      <= '0;
            rd2_e_q      <= '0;
            imm_e_q      <= '0;
            pc_e_q       <= '0;
            pc_plus4_e_q <= '0;
            rs1_e_q      <= '0;
            rs2_e_q      <= '0;
            rd_e_q       <= '0;
        end else begin
            valid_e_q    <= valid_e_d;
            ctrl_e_q     <= ctrl_e_d;
            is_load_e_q  <= is_load_e_d;
            rd1_e_q      <= rd1_e_d;
            rd2_e_q      <= rd2_e_d;
            imm_e_q      <= imm_e_d;
            pc_e_q       <= pc_e_d;
            pc_plus4_e_q <= pc_plus4_e_d;
            rs1_e_q      <= rs1_e_d;
            rs2_e_q      <= rs2_e_d;
            rd_e_q       <= rd_e_d;
        end
    end

    assign valid_e    = valid_e_q;
    assign ctrl_e     = ctrl_e_q;
    assign is_load_e  = is_load_e_q;
    assign rd1_e      = rd1_e_q;
    assign rd2_e      = rd2_e_q;
    assign imm_e      = imm_e_q;
    assign pc_e       = pc_e_q;
    assign pc_plus4_e = pc_plus4_e_q;
    assign rs1_e      = rs1_e_q;
    assign rs2_e      = rs2_e_q;
    assign rd_e       = rd_e_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model; second instance at XLEN=64/NREG=16.
module tb_decode_stage_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default instance (XLEN=32, NREG=32, CTRL_W=24)
    logic        rst, valid_d, is_load_d, reg_write_w, flush_e, hold_i;
    logic [31:0] instr_d, pc_d, pc_plus4_d, imm_ext_d, result_w;
    logic [23:0] ctrl_d;
    logic [4:0]  rd_w;
    logic        stall_d, valid_e, is_load_e;
    logic [23:0] ctrl_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;

    decode_stage_pipe dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .imm_ext_d(imm_ext_d), .ctrl_d(ctrl_d),
        .is_load_d(is_load_d), .reg_write_w(reg_write_w), .rd_w(rd_w),
        .result_w(result_w), .flush_e(flush_e), .hold_i(hold_i), .stall_d(stall_d),
        .valid_e(valid_e), .ctrl_e(ctrl_e), .is_load_e(is_load_e), .rd1_e(rd1_e),
        .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
    );

    // ---------------- wide instance (XLEN=64, NREG=16, CTRL_W=8)
    logic        p_rst, p_valid_d, p_is_load_d, p_reg_write_w, p_flush_e, p_hold_i;
    logic [31:0] p_instr_d;
    logic [63:0] p_pc_d, p_pc_plus4_d, p_imm_ext_d, p_result_w;
    logic [7:0]  p_ctrl_d;
    logic [3:0]  p_rd_w;
    logic        p_stall_d, p_valid_e, p_is_load_e;
    logic [7:0]  p_ctrl_e;
    logic [63:0] p_rd1_e, p_rd2_e, p_imm_e, p_pc_e, p_pc_plus4_e;
    logic [3:0]  p_rs1_e, p_rs2_e, p_rd_e;

    decode_stage_pipe #(.XLEN(64), .NREG(16), .CTRL_W(8)) dut64 (
        .clk(clk), .rst(p_rst), .valid_d(p_valid_d), .instr_d(p_instr_d), .pc_d(p_pc_d),
        .pc_plus4_d(p_pc_plus4_d), .imm_ext_d(p_imm_ext_d), .ctrl_d(p_ctrl_d),
        .is_load_d(p_is_load_d), .reg_write_w(p_reg_write_w), .rd_w(p_rd_w),
        .result_w(p_result_w), .flush_e(p_flush_e), .hold_i(p_hold_i), .stall_d(p_stall_d),
        .valid_e(p_valid_e), .ctrl_e(p_ctrl_e), .is_load_e(p_is_load_e), .rd1_e(p_rd1_e),
        .rd2_e(p_rd2_e), .imm_e(p_imm_e), .pc_e(p_pc_e), .pc_plus4_e(p_pc_plus4_e),
        .rs1_e(p_rs1_e), .rs2_e(p_rs2_e), .rd_e(p_rd_e)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: architectural register array plus the expected E-stage contents.
    logic [31:0] m_regs [32];
    logic        m_valid, m_is_load, m_full;
    logic [23:0] m_ctrl;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pc4;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic        last_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [6:0] op);
        return {7'b0, rs2, rs1, 3'b0, rd, op};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        if (reg_write_w && rd_w == rs) return result_w;
        return m_regs[rs];
    endfunction

    task automatic m_bubble();
        m_valid = 1'b0; m_ctrl = '0; m_is_load = 1'b0; m_rd1 = '0; m_rd2 = '0;
        m_imm = '0; m_pc = '0; m_pc4 = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        m_full = 1'b1;
    endtask

    // One clock: check stall_d before the edge, advance the model, check E outputs after.
    task automatic step();
        logic [4:0] s1, s2;
        logic       lu;
        @(negedge clk);
        s1 = instr_d[19:15];
        s2 = instr_d[24:20];
        lu = valid_d && m_valid && m_is_load && (m_rd != 5'd0) && (m_rd == s1 || m_rd == s2);
        last_stall = stall_d;
        chk("stall_d", 64'(stall_d), 64'(hold_i | (lu & ~flush_e)));
        if (rst) begin
            m_bubble();
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end else begin
            if (flush_e) m_bubble();
            else if (hold_i) begin end
            else if (lu) m_bubble();
            else begin
                m_valid = valid_d;
                m_ctrl  = valid_d ? ctrl_d : 24'd0;
                m_full  = valid_d;
                if (valid_d) begin
                    m_is_load = is_load_d; m_rd1 = m_read(s1); m_rd2 = m_read(s2);
                    m_imm = imm_ext_d; m_pc = pc_d; m_pc4 = pc_plus4_d;
                    m_rs1 = s1; m_rs2 = s2; m_rd = instr_d[11:7];
                end
            end
            if (reg_write_w && rd_w != 5'd0) m_regs[rd_w] = result_w;
        end
        @(posedge clk);
        #1;
        chk("valid_e", 64'(valid_e), 64'(m_valid));
        chk("ctrl_e", 64'(ctrl_e), 64'(m_ctrl));
        if (m_full) begin
            chk("is_load_e", 64'(is_load_e), 64'(m_is_load));
            chk("rd1_e", 64'(rd1_e), 64'(m_rd1));
            chk("rd2_e", 64'(rd2_e), 64'(m_rd2));
            chk("imm_e", 64'(imm_e), 64'(m_imm));
            chk("pc_e", 64'(pc_e), 64'(m_pc));
            chk("pc_plus4_e", 64'(pc_plus4_e), 64'(m_pc4));
            chk("rs1_e", 64'(rs1_e), 64'(m_rs1));
            chk("rs2_e", 64'(rs2_e), 64'(m_rs2));
            chk("rd_e", 64'(rd_e), 64'(m_rd));
        end
    endtask

    task automatic set_idle();
        rst = 1'b0; valid_d = 1'b0; is_load_d = 1'b0; reg_write_w = 1'b0;
        flush_e = 1'b0; hold_i = 1'b0; instr_d = '0; pc_d = '0; pc_plus4_d = '0;
        imm_ext_d = '0; result_w = '0; ctrl_d = '0; rd_w = '0;
    endtask

    task automatic decode(input logic [31:0] ins, input logic ld);
        valid_d = 1'b1; instr_d = ins; is_load_d = ld;
        ctrl_d = 24'($urandom); imm_ext_d = $urandom;
        pc_d = $urandom; pc_plus4_d = pc_d + 32'd4;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        m_bubble();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;

        // Wide instance: write x15, read it back, index truncation and 64-bit bypass.
        p_rst = 1'b1; p_valid_d = 1'b0; p_is_load_d = 1'b0; p_reg_write_w = 1'b0;
        p_flush_e = 1'b0; p_hold_i = 1'b0; p_instr_d = '0; p_pc_d = '0;
        p_pc_plus4_d = '0; p_imm_ext_d = '0; p_result_w = '0; p_ctrl_d = '0; p_rd_w = '0;
        @(posedge clk); #1;
        p_rst = 1'b0; p_reg_write_w = 1'b1; p_rd_w = 4'd15;
        p_result_w = 64'hFFFF_0000_1234_5678;
        @(posedge clk); #1;
        p_reg_write_w = 1'b0; p_valid_d = 1'b1; p_ctrl_d = 8'h5A;
        p_instr_d = mk_instr(5'd1, 5'd0, 5'd15, 7'h33);
        p_pc_d = 64'hAAAA_BBBB_CCCC_DDDD;
        @(posedge clk); #1;
        chk("w64_rd2_x15", p_rd2_e, 64'hFFFF_0000_1234_5678);
        chk("w64_valid", 64'(p_valid_e), 64'd1);
        chk("w64_pc", p_pc_e, 64'hAAAA_BBBB_CCCC_DDDD);
        p_instr_d = mk_instr(5'd1, 5'd14, 5'd31, 7'h33);
        p_reg_write_w = 1'b1; p_rd_w = 4'd14; p_result_w = 64'h8000_0000_0000_0001;
        @(posedge clk); #1;
        chk("w64_rs2_trunc", p_rd2_e, 64'hFFFF_0000_1234_5678);
        chk("w64_bypass", p_rd1_e, 64'h8000_0000_0000_0001);
        chk("w64_rs2_idx", 64'(p_rs2_e), 64'd15);
        p_reg_write_w = 1'b0; p_valid_d = 1'b0;

        // Reset then read.
        step();
        rst = 1'b0;
        decode(mk_instr(5'd1, 5'd5, 5'd0, 7'h33), 1'b0);
        step();
        chk("t1_rd1", 64'(rd1_e), 64'd0);
        chk("t1_rd2", 64'(rd2_e), 64'd0);
        chk("t1_valid", 64'(valid_e), 64'd1);

        // Write-back bypass and x0 write protection.
        reg_write_w = 1'b1; rd_w = 5'd7; result_w = 32'hDEADBEEF;
        decode(mk_instr(5'd2, 5'd7, 5'd0, 7'h33), 1'b0);
        step();
        chk("t2_bypass", 64'(rd1_e), 64'hDEADBEEF);
        rd_w = 5'd0; result_w = 32'h1234;
        decode(mk_instr(5'd2, 5'd0, 5'd7, 7'h33), 1'b0);
        step();
        chk("t2_x0", 64'(rd1_e), 64'd0);
        chk("t2_stored", 64'(rd2_e), 64'hDEADBEEF);
        reg_write_w = 1'b0;

        // Load-use: one stall, one bubble, then the add is captured.
        decode(mk_instr(5'd3, 5'd1, 5'd2, 7'h03), 1'b1);
        step();
        decode(mk_instr(5'd4, 5'd3, 5'd1, 7'h33), 1'b0);
        step();
        chk("t3_stall", 64'(last_stall), 64'd1);
        chk("t3_bubble_v", 64'(valid_e), 64'd0);
        chk("t3_bubble_c", 64'(ctrl_e), 64'd0);
        step();
        chk("t3_nostall", 64'(last_stall), 64'd0);
        chk("t3_add_v", 64'(valid_e), 64'd1);
        chk("t3_add_rd", 64'(rd_e), 64'd4);
        decode(mk_instr(5'd0, 5'd1, 5'd2, 7'h03), 1'b1);
        step();
        decode(mk_instr(5'd4, 5'd0, 5'd1, 7'h33), 1'b0);
        step();
        chk("t3_rd0_nostall", 64'(last_stall), 64'd0);

        // Flush priority over hold and load-use.
        decode(mk_instr(5'd3, 5'd1, 5'd2, 7'h03), 1'b1);
        step();
        decode(mk_instr(5'd4, 5'd3, 5'd1, 7'h33), 1'b0);
        flush_e = 1'b1; hold_i = 1'b1;
        step();
        chk("t4_stall_hold", 64'(last_stall), 64'd1);
        chk("t4_valid", 64'(valid_e), 64'd0);
        chk("t4_ctrl", 64'(ctrl_e), 64'd0);
        flush_e = 1'b0; hold_i = 1'b0;
        decode(mk_instr(5'd3, 5'd1, 5'd2, 7'h03), 1'b1);
        step();
        decode(mk_instr(5'd4, 5'd3, 5'd1, 7'h33), 1'b0);
        flush_e = 1'b1;
        step();
        chk("t4_flush_masks_lu", 64'(last_stall), 64'd0);
        chk("t4_valid2", 64'(valid_e), 64'd0);
        flush_e = 1'b0;

        // Hold for three cycles while D changes.
        decode(mk_instr(5'd5, 5'd6, 5'd7, 7'h33), 1'b0);
        pc_d = 32'h100;
        step();
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            decode(mk_instr(5'd9, 5'd10, 5'd11, 7'h33), 1'b0);
            pc_d = 32'h200 + 32'(i);
            step();
            chk("t5_stall", 64'(last_stall), 64'd1);
            chk("t5_pc_frozen", 64'(pc_e), 64'h100);
        end
        hold_i = 1'b0;
        pc_d = 32'h300;
        step();
        chk("t5_resume", 64'(pc_e), 64'h300);

        // Randomized traffic; small register range to provoke hazards and bypasses.
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            flush_e     = ($urandom_range(0, 7) == 0);
            hold_i      = ($urandom_range(0, 5) == 0);
            valid_d     = ($urandom_range(0, 7) != 0);
            is_load_d   = ($urandom_range(0, 2) == 0);
            instr_d     = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           3'($urandom), 5'($urandom_range(0, 7)), 7'($urandom)};
            ctrl_d      = 24'($urandom);
            imm_ext_d   = $urandom;
            pc_d        = $urandom;
            pc_plus4_d  = pc_d + 32'd4;
            reg_write_w = $urandom_range(0, 1) == 1;
            rd_w        = 5'($urandom_range(0, 7));
            result_w    = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised decode stage for the pipelined RISC-V core.
- Owns the integer register file, with write-back bypass on reads.
- Detects load-use hazards and generates the decode/fetch stall.
- Registers all decode results into an ID/EX pipeline register with flush, hold and bubble insertion.
- Instruction decoding and immediate extension stay in the existing control unit and immediate extender; their outputs arrive here as ctrl_d and imm_ext_d.

Parameters:
- XLEN, 32, datapath width (register, PC and immediate width).
- NREG, 32, number of architectural registers; AW = $clog2(NREG) is the register index width.
- CTRL_W, 24, width of the packed control bundle from the control unit.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_d  in  1  decode slot holds a real instruction.
- instr_d  in  32  instruction word. rs1 = [19:15], rs2 = [24:20], rd = [11:7], each truncated to AW bits.
- pc_d  in  XLEN  PC of the decode instruction.
- pc_plus4_d  in  XLEN  PC+4 of the decode instruction.
- imm_ext_d  in  XLEN  extended immediate.
- ctrl_d  in  CTRL_W  packed control bundle.
- is_load_d  in  1  decode instruction is a load.
- reg_write_w  in  1  write-back enable.
- rd_w  in  AW  write-back destination register.
- result_w  in  XLEN  write-back data.
- flush_e  in  1  squash the instruction entering E (taken branch or jump).
- hold_i  in  1  downstream stall; freeze the ID/EX register.
- stall_d  out  1  upstream must hold the F/D registers and the PC.
- valid_e  out  1  ID/EX register holds a real instruction.
- ctrl_e  out  CTRL_W  registered control bundle.
- is_load_e  out  1  registered load flag.
- rd1_e, rd2_e  out  XLEN  registered operand values.
- imm_e, pc_e, pc_plus4_e  out  XLEN  registered immediate, PC and PC+4.
- rs1_e, rs2_e, rd_e  out  AW  registered register indices.

Behaviour:
- Register file: NREG x XLEN.
  - Register 0 always reads 0; writes to it are ignored.
  - Write on the clk edge when reg_write_w=1 and rd_w!=0.
  - rst clears all registers to 0 in the same cycle.
- Read port (combinational): if reg_write_w=1, rd_w==rs and rs!=0, the read returns result_w (same-cycle bypass); otherwise it returns the stored value. rs==0 always returns 0.
- Load-use hazard: load_use = valid_d & valid_e & is_load_e & (rd_e!=0) & ((rd_e==rs1) | (rd_e==rs2)).
  - The comparison is conservative: both rs fields are checked regardless of instruction format.
- stall_d = hold_i | (load_use & ~flush_e). It is combinational, with no latency.
- ID/EX register update, in priority order per edge:
  1. rst: all outputs become 0, including valid_e=0 and ctrl_e=0.
  2. flush_e: bubble. valid_e=0, ctrl_e=0, is_load_e=0; other fields are don't-care but driven to 0. flush_e overrides hold_i.
  3. hold_i: all E outputs keep their values.
  4. load_use: bubble, same encoding as flush. The D-stage instruction is retained upstream via stall_d and re-decoded next cycle, when it reads the forwarded or bypassed value.
  5. Otherwise, capture the D-stage values.
     - If valid_d=0, valid_e=0 and ctrl_e=0.
- A bubble always forces ctrl_e=0, so no write, memory or branch effect can leak from a bubble.
- Reset mid-operation: pending hazards are discarded. The first edge with rst=0 captures normally.
- Latency: D to E is one cycle. A load-use hazard costs exactly one bubble.
- No combinational path from result_w to E outputs, other than through the registered capture.

Test Plan:
1. Reset then read:
   - rst=1 for one cycle, then decode an instruction with rs1=5 and rs2=0.
   - Required: rd1_e=0, rd2_e=0, valid_e=1 on the next edge.
2. Write-back bypass:
   - Same cycle: reg_write_w=1, rd_w=7, result_w=0xDEADBEEF, decode rs1=7.
   - Required: rd1_e=0xDEADBEEF on the next edge.
   - Writing rd_w=0 with 0x1234 must still read 0 from register 0.
3. Load-use:
   - Load to x3 sits in E (is_load_e=1, rd_e=3); decode `add x4,x3,x1`.
   - Required: stall_d=1 for exactly one cycle, then one bubble (valid_e=0, ctrl_e=0).
   - The add is captured on the following edge.
   - Repeat with rd_e=0: required stall_d=0.
4. Flush priority:
   - flush_e=1 together with hold_i=1 and load_use.
   - Required: next edge gives valid_e=0, ctrl_e=0; stall_d=1 only because of hold_i.
5. Hold:
   - hold_i=1 for 3 cycles while D changes.
   - Required: all E outputs stay constant and stall_d=1. Capture resumes on the first edge after hold_i drops.
6. Parameter sweep:
   - NREG=16, XLEN=64: write x15 = 0xFFFF_0000_1234_5678, then read it back.
   - Required: the exact value on rd2_e with instr rs2=15.
